// File: rtl/mult_div_pkg.sv
// Shared encodings for the MULT/DIV sequencer: op codes, FSM states and the
// default iteration count.
package mult_div_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned magnitude datapath: a shift-add
// multiply step or a restoring-divide step, selected by i_op.
module muldiv_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_trial;

    // The carry out of the add becomes the top bit of the shifted accumulator.
    assign w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    assign w_shl   = {i_acc, i_q[WIDTH-1]};
    assign w_trial = w_shl - {1'b0, i_opnd};

    always_comb begin
        o_acc = w_sum[WIDTH:1];
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        if (i_op == OP_DIV) begin
            if (!w_trial[WIDTH]) begin
                o_acc = w_trial[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shl[WIDTH-1:0];
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle signed MULT/DIV sequencer owning HI/LO: runs WIDTH magnitude
// iterations, then applies sign correction and commits to hi/lo.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = ITER,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic             r_neg_res;
    logic             r_neg_dvd;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_opnd;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // Unsigned magnitude: the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic n, input logic [WIDTH-1:0] x);
        return n ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic n, input logic [2*WIDTH-1:0] x);
        return n ? (~x + 1'b1) : x;
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt),
        .o_q    (w_q_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (op == OP_DIV && b == '0) begin
                            r_state <= ZERO;
                        end else begin
                            // r_q holds the multiplier or dividend, r_opnd the multiplicand or divisor.
                            r_op      <= op;
                            r_q       <= (op == OP_MULT) ? mag(b) : mag(a);
                            r_opnd    <= (op == OP_MULT) ? mag(a) : mag(b);
                            r_acc     <= '0;
                            r_neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_neg_dvd <= a[WIDTH-1];
                            r_cnt     <= '0;
                            r_state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (r_op == OP_MULT) begin
                        {r_hi, r_lo} <= neg_2w(r_neg_res, {r_acc, r_q});
                    end else begin
                        r_lo <= neg_w(r_neg_res, r_q);
                        r_hi <= neg_w(r_neg_dvd, r_acc);
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                ZERO: begin
                    r_done     <= 1'b1;
                    r_div_zero <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: signed MULT/DIV results, latency, div-by-zero,
// ignored start while busy, back-to-back launch and mid-operation reset.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge; returns in the cycle done is high.
    task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                          input logic [31:0] y, input int glitch,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int busy_low;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        lat = 0;
        busy_low = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == glitch) begin
                start = 1'b1; op = ~o; a = 32'h0000_0055; b = 32'h0000_0003;
            end else begin
                start = 1'b0;
            end
            if (done) break;
            if (!busy) busy_low++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_busy_low_cycles"}, 32'(busy_low), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_div_zero"}, 32'(div_zero), 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int dcount;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mul_7_m3", 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0000_0000);
        run_op("mul_zero", 1'b0, 32'h0000_0000, 32'h1234_5678, 0, 32'h0000_0000, 32'h0000_0000);
        run_op("div_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000);
        run_op("div_100_7", 1'b1, 32'h0000_0064, 32'h0000_0007, 0, 32'h0000_0002, 32'h0000_000E);

        // Preload hi/lo, then divide by zero.
        run_op("mul_m1_5", 1'b0, 32'hFFFF_FFFF, 32'h0000_0005, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        @(negedge clk);
        op = 1'b1; a = 32'd5; b = 32'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("dz_busy", 32'(busy), 32'd1);
        check("dz_done_early", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("dz_done", 32'(done), 32'd1);
        check("dz_flag", 32'(div_zero), 32'd1);
        check("dz_hi", hi, 32'hFFFF_FFFF);
        check("dz_lo", lo, 32'hFFFF_FFFB);
        @(posedge clk);
        @(negedge clk);
        check("dz_busy_after", 32'(busy), 32'd0);
        check("dz_done_after", 32'(done), 32'd0);
        check("dz_flag_after", 32'(div_zero), 32'd0);

        // Start pulse at cycle 5 is ignored; new start in the done cycle is accepted.
        run_op("mul_6_7_glitch", 1'b0, 32'h0000_0006, 32'h0000_0007, 5, 32'h0000_0000, 32'h0000_002A);
        run_op("mul_2_m1_b2b", 1'b0, 32'h0000_0002, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Reset in the middle of a DIV.
        @(negedge clk);
        op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        reset = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dcount++;
        end
        check("mid_rst_no_done", 32'(dcount), 32'd0);
        run_op("mul_3_4", 1'b0, 32'h0000_0003, 32'h0000_0004, 0, 32'h0000_0000, 32'h0000_000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
